// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types and default constants for the FIFO write arbiter
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_NUM_REQ    = 4;
  localparam int DEFAULT_MAX_BURST  = 4;
  localparam int BEAT_WIDTH         = 5;
  localparam int COUNT_WIDTH        = 16;

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - round-robin search for the first valid requester from rr_ptr
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [ID_W-1:0]    sel,
  output logic               found
);

  logic [ID_W-1:0] idx;

  // Walk the offsets from farthest to nearest so the nearest valid requester wins.
  always_comb begin
    sel   = rr_ptr;
    found = 1'b0;
    idx   = rr_ptr;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = ID_W'((int'(rr_ptr) + i) % NUM_REQ);
      if (valid[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// rtl/fifo_write_arbiter.sv - round-robin burst arbiter feeding a single FIFO write port
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int NUM_REQ    = DEFAULT_NUM_REQ,
  parameter int MAX_BURST  = DEFAULT_MAX_BURST
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic                            fifo_full,
  output logic                            fifo_write_enable,
  output logic [DATA_WIDTH-1:0]           fifo_write_data,
  output logic [$clog2(NUM_REQ)-1:0]      grant_id,
  output logic                            busy,
  output logic [NUM_REQ*COUNT_WIDTH-1:0]  grant_count
);

  localparam int ID_W = $clog2(NUM_REQ);

  arb_state_t            state, state_nxt;
  logic [ID_W-1:0]       owner, owner_nxt;
  logic [ID_W-1:0]       rr_ptr, rr_ptr_nxt;
  logic [BEAT_WIDTH-1:0] beat_cnt, beat_nxt, beat_inc;
  logic [ID_W-1:0]       pick_sel, sel;
  logic                  pick_found, active, xfer;

  function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] v);
    return (int'(v) == NUM_REQ - 1) ? '0 : v + ID_W'(1);
  endfunction

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_picker (
    .valid  (req_valid),
    .rr_ptr (rr_ptr),
    .sel    (pick_sel),
    .found  (pick_found)
  );

  // The owner keeps the grant for the whole burst; otherwise the picker decides.
  assign sel      = (state == BURST) ? owner : pick_sel;
  assign active   = !reset && ((state == BURST) || pick_found);
  assign beat_inc = beat_cnt + BEAT_WIDTH'(1);
  assign busy     = (state == BURST);
  assign grant_id = sel;

  // Only the selected requester may see ready, and only while the FIFO has room.
  always_comb begin
    req_ready = '0;
    if (active && !fifo_full) req_ready[sel] = 1'b1;
  end

  assign xfer              = req_valid[sel] && req_ready[sel];
  assign fifo_write_enable = xfer;

  // Steer the selected requester's data slice onto the FIFO port.
  always_comb begin
    fifo_write_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel == ID_W'(i)) fifo_write_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Burst bookkeeping: open on first beat, close on MAX_BURST or when the owner drops valid.
  always_comb begin
    state_nxt  = state;
    owner_nxt  = owner;
    rr_ptr_nxt = rr_ptr;
    beat_nxt   = beat_cnt;
    case (state)
      IDLE: begin
        if (xfer) begin
          if (MAX_BURST > 1) begin
            state_nxt = BURST;
            owner_nxt = sel;
            beat_nxt  = BEAT_WIDTH'(1);
          end else begin
            rr_ptr_nxt = wrap_inc(sel);
          end
        end
      end
      BURST: begin
        if (!req_valid[owner]) begin
          state_nxt  = IDLE;
          rr_ptr_nxt = wrap_inc(owner);
          beat_nxt   = '0;
        end else if (xfer) begin
          if (beat_inc == BEAT_WIDTH'(MAX_BURST)) begin
            state_nxt  = IDLE;
            rr_ptr_nxt = wrap_inc(owner);
            beat_nxt   = '0;
          end else begin
            beat_nxt = beat_inc;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Arbiter state register; reset restarts arbitration at requester 0.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      owner    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      owner    <= owner_nxt;
      rr_ptr   <= rr_ptr_nxt;
      beat_cnt <= beat_nxt;
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_count
    logic [COUNT_WIDTH-1:0] cnt;

    // Saturating per-requester beat counter.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        cnt <= '0;
      end else if (xfer && (sel == ID_W'(g)) && (cnt != {COUNT_WIDTH{1'b1}})) begin
        cnt <= cnt + COUNT_WIDTH'(1);
      end
    end

    assign grant_count[g*COUNT_WIDTH +: COUNT_WIDTH] = cnt;
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb/tb_fifo_write_arbiter.sv - self-checking bench for fifo_write_arbiter
module tb_fifo_write_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    req_ready;
  logic            fifo_full = 1'b0;
  logic            fifo_write_enable;
  logic [DW-1:0]   fifo_write_data;
  logic [1:0]      grant_id;
  logic            busy;
  logic [N*16-1:0] grant_count;

  int n_vec = 0;
  int n_err = 0;

  // reference model: owner -1 means no burst in progress
  int           m_owner = -1;
  int           m_beats = 0;
  int           m_ptr   = 0;
  int           m_cnt[N];
  int           m_sel;
  bit           m_found;
  logic [N-1:0] m_ready;
  logic         m_we;
  logic [DW-1:0] m_data;
  logic [N*16-1:0] m_gc;

  fifo_write_arbiter #(
    .DATA_WIDTH (DW),
    .NUM_REQ    (N),
    .MAX_BURST  (MB)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .req_valid         (req_valid),
    .req_data          (req_data),
    .req_ready         (req_ready),
    .fifo_full         (fifo_full),
    .fifo_write_enable (fifo_write_enable),
    .fifo_write_data   (fifo_write_data),
    .grant_id          (grant_id),
    .busy              (busy),
    .grant_count       (grant_count)
  );

  always #5 clock = ~clock;

  task automatic model_eval;
    m_found = 1'b0;
    m_sel   = m_ptr;
    if (m_owner >= 0) begin
      m_sel   = m_owner;
      m_found = 1'b1;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (!m_found && req_valid[(m_ptr + k) % N]) begin
          m_sel   = (m_ptr + k) % N;
          m_found = 1'b1;
        end
      end
    end
    m_ready = (m_found && !fifo_full && !reset) ? N'(1 << m_sel) : '0;
    m_we    = m_found && req_valid[m_sel] && !fifo_full && !reset;
    m_data  = req_data[m_sel*DW +: DW];
    for (int k = 0; k < N; k++) m_gc[k*16 +: 16] = 16'(m_cnt[k]);
  endtask

  task automatic model_commit;
    if (reset) begin
      m_owner = -1;
      m_beats = 0;
      m_ptr   = 0;
      for (int k = 0; k < N; k++) m_cnt[k] = 0;
    end else begin
      if (m_we && m_cnt[m_sel] < 65535) m_cnt[m_sel] = m_cnt[m_sel] + 1;
      if (m_owner < 0) begin
        if (m_we) begin
          if (MB > 1) begin
            m_owner = m_sel;
            m_beats = 1;
          end else begin
            m_ptr = (m_sel + 1) % N;
          end
        end
      end else if (!req_valid[m_owner]) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
        m_beats = 0;
      end else if (m_we) begin
        m_beats = m_beats + 1;
        if (m_beats == MB) begin
          m_ptr   = (m_owner + 1) % N;
          m_owner = -1;
          m_beats = 0;
        end
      end
    end
  endtask

  task automatic set_in(input logic [N-1:0] v, input logic full);
    req_valid = v;
    fifo_full = full;
    req_data  = N*DW'($urandom);
    model_eval();
    #1;
  endtask

  task automatic advance;
    model_commit();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_reset;
    reset     = 1'b1;
    req_valid = '0;
    fifo_full = 1'b0;
    @(negedge clock);
    model_commit();
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset     = 1'b1;
    req_valid = 4'hF;
    fifo_full = 1'b0;
    req_data  = N*DW'($urandom);
    @(negedge clock);
    @(negedge clock);
    #1;
    n_vec++; if (req_ready !== 4'h0) begin n_err++; $display("FAIL reset_ready: got %h expected 0", req_ready); end
    n_vec++; if (fifo_write_enable !== 1'b0) begin n_err++; $display("FAIL reset_we: got %b expected 0", fifo_write_enable); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_vec++; if (grant_count !== '0) begin n_err++; $display("FAIL reset_count: got %h expected 0", grant_count); end
    model_commit();
    reset = 1'b0;
    set_in(4'hF, 1'b0);
    n_vec++; if (grant_id !== 2'd0) begin n_err++; $display("FAIL reset_first_grant: got %0d expected 0", grant_id); end
    advance();
  endtask

  task automatic test_alternate;
    int exp_id;
    do_reset();
    for (int c = 0; c < 16; c++) begin
      set_in(4'b0101, 1'b0);
      exp_id = ((c / 4) % 2 == 0) ? 0 : 2;
      n_vec++; if (grant_id !== 2'(exp_id)) begin n_err++; $display("FAIL alt_grant c=%0d: got %0d expected %0d", c, grant_id, exp_id); end
      n_vec++; if (fifo_write_enable !== 1'b1) begin n_err++; $display("FAIL alt_we c=%0d: got %b expected 1", c, fifo_write_enable); end
      advance();
    end
    n_vec++; if (grant_count[15:0] !== 16'd8) begin n_err++; $display("FAIL alt_count0: got %0d expected 8", grant_count[15:0]); end
    n_vec++; if (grant_count[47:32] !== 16'd8) begin n_err++; $display("FAIL alt_count2: got %0d expected 8", grant_count[47:32]); end
  endtask

  task automatic test_early_drop;
    do_reset();
    for (int c = 0; c < 2; c++) begin
      set_in(4'b0010, 1'b0);
      n_vec++; if (fifo_write_enable !== 1'b1) begin n_err++; $display("FAIL drop_we c=%0d: got %b expected 1", c, fifo_write_enable); end
      advance();
    end
    set_in(4'b0000, 1'b0);
    n_vec++; if (fifo_write_enable !== 1'b0) begin n_err++; $display("FAIL drop_idle_we: got %b expected 0", fifo_write_enable); end
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL drop_busy_hold: got %b expected 1", busy); end
    advance();
    set_in(4'b0000, 1'b0);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL drop_busy_fall: got %b expected 0", busy); end
    n_vec++; if (req_ready !== 4'h0) begin n_err++; $display("FAIL drop_ready: got %h expected 0", req_ready); end
    advance();
    set_in(4'b0110, 1'b0);
    n_vec++; if (grant_id !== 2'd2) begin n_err++; $display("FAIL drop_rr_ptr: got %0d expected 2", grant_id); end
    advance();
  endtask

  task automatic test_full_stall;
    do_reset();
    for (int c = 0; c < 7; c++) begin
      set_in(4'b0001, (c >= 2 && c <= 4));
      if (c >= 2 && c <= 4) begin
        n_vec++; if (req_ready !== 4'h0) begin n_err++; $display("FAIL stall_ready c=%0d: got %h expected 0", c, req_ready); end
        n_vec++; if (fifo_write_enable !== 1'b0) begin n_err++; $display("FAIL stall_we c=%0d: got %b expected 0", c, fifo_write_enable); end
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL stall_busy c=%0d: got %b expected 1", c, busy); end
      end else begin
        n_vec++; if (fifo_write_enable !== 1'b1) begin n_err++; $display("FAIL stall_beat c=%0d: got %b expected 1", c, fifo_write_enable); end
      end
      advance();
    end
    set_in(4'b0000, 1'b0);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL stall_done_busy: got %b expected 0", busy); end
    n_vec++; if (grant_count[15:0] !== 16'd4) begin n_err++; $display("FAIL stall_count: got %0d expected 4", grant_count[15:0]); end
    advance();
  endtask

  task automatic test_rotation;
    int exp_id;
    do_reset();
    for (int c = 0; c < 4; c++) begin
      set_in(4'b0100, 1'b0);
      advance();
    end
    for (int c = 0; c < 16; c++) begin
      set_in(4'b1111, 1'b0);
      exp_id = (3 + c / 4) % 4;
      n_vec++; if (grant_id !== 2'(exp_id)) begin n_err++; $display("FAIL rot_grant c=%0d: got %0d expected %0d", c, grant_id, exp_id); end
      n_vec++; if (fifo_write_enable !== 1'b1) begin n_err++; $display("FAIL rot_we c=%0d: got %b expected 1", c, fifo_write_enable); end
      advance();
    end
  endtask

  task automatic test_reset_mid_burst;
    do_reset();
    set_in(4'b0100, 1'b0);
    advance();
    set_in(4'b0100, 1'b0);
    n_vec++; if (fifo_write_enable !== 1'b1) begin n_err++; $display("FAIL mid_beat2_we: got %b expected 1", fifo_write_enable); end
    reset = 1'b1;
    #1;
    n_vec++; if (fifo_write_enable !== 1'b0) begin n_err++; $display("FAIL mid_reset_we: got %b expected 0", fifo_write_enable); end
    n_vec++; if (req_ready !== 4'h0) begin n_err++; $display("FAIL mid_reset_ready: got %h expected 0", req_ready); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_reset_busy: got %b expected 0", busy); end
    advance();
    reset = 1'b0;
    set_in(4'b1111, 1'b0);
    n_vec++; if (grant_id !== 2'd0) begin n_err++; $display("FAIL mid_resume_grant: got %0d expected 0", grant_id); end
    n_vec++; if (grant_count !== '0) begin n_err++; $display("FAIL mid_resume_count: got %h expected 0", grant_count); end
    advance();
  endtask

  task automatic test_random;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      set_in(N'($urandom), ($urandom_range(0, 3) == 0));
      n_vec++; if (req_ready !== m_ready) begin n_err++; $display("FAIL rnd_ready c=%0d: got %h expected %h", c, req_ready, m_ready); end
      n_vec++; if (fifo_write_enable !== m_we) begin n_err++; $display("FAIL rnd_we c=%0d: got %b expected %b", c, fifo_write_enable, m_we); end
      n_vec++; if (busy !== (m_owner >= 0)) begin n_err++; $display("FAIL rnd_busy c=%0d: got %b expected %b", c, busy, (m_owner >= 0)); end
      n_vec++; if (grant_count !== m_gc) begin n_err++; $display("FAIL rnd_count c=%0d: got %h expected %h", c, grant_count, m_gc); end
      if (m_found) begin
        n_vec++; if (grant_id !== 2'(m_sel)) begin n_err++; $display("FAIL rnd_grant c=%0d: got %0d expected %0d", c, grant_id, m_sel); end
      end
      if (m_we) begin
        n_vec++; if (fifo_write_data !== m_data) begin n_err++; $display("FAIL rnd_data c=%0d: got %h expected %h", c, fifo_write_data, m_data); end
      end
      advance();
    end
  endtask

  task automatic test_saturation;
    int exp_cnt;
    do_reset();
    for (int c = 0; c < 65534; c++) begin
      set_in(4'b0001, 1'b0);
      advance();
    end
    n_vec++; if (grant_count[15:0] !== 16'hFFFE) begin n_err++; $display("FAIL sat_preload: got %h expected fffe", grant_count[15:0]); end
    exp_cnt = 65534;
    for (int c = 0; c < 3; c++) begin
      set_in(4'b0001, 1'b0);
      advance();
      exp_cnt = (exp_cnt + 1 > 65535) ? 65535 : exp_cnt + 1;
      n_vec++; if (grant_count[15:0] !== 16'(exp_cnt)) begin n_err++; $display("FAIL sat_hold c=%0d: got %h expected %h", c, grant_count[15:0], 16'(exp_cnt)); end
    end
    n_vec++; if (grant_count[15:0] !== 16'hFFFF) begin n_err++; $display("FAIL sat_final: got %h expected ffff", grant_count[15:0]); end
  endtask

  initial begin
    for (int k = 0; k < N; k++) m_cnt[k] = 0;
    test_reset();
    test_alternate();
    test_early_drop();
    test_full_stall();
    test_rotation();
    test_reset_mid_burst();
    test_random();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_write_arbiter.md
FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8: width of each requester data word and of the FIFO write port.
REQ-002 The block SHALL have parameter NUM_REQ, default 4, legal range 2..8: number of requesters.
REQ-003 The block SHALL have parameter MAX_BURST, default 4, legal range 1..16: maximum consecutive beats per grant.
REQ-004 Port clock, input, 1: clock; all state changes on its rising edge.
REQ-005 Port reset, input, 1: reset, asynchronous, active-high.
REQ-006 Port req_valid, input, NUM_REQ: per-requester data-valid.
REQ-007 Port req_data, input, NUM_REQ*DATA_WIDTH: requester i data occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 Port req_ready, output, NUM_REQ: per-requester accept; a beat transfers when req_valid[i] and req_ready[i] are both high.
REQ-009 Port fifo_full, input, 1: downstream FIFO full flag.
REQ-010 Port fifo_write_enable, output, 1: write strobe to the FIFO.
REQ-011 Port fifo_write_data, output, DATA_WIDTH: write data to the FIFO.
REQ-012 Port grant_id, output, clog2(NUM_REQ): index of the currently selected requester.
REQ-013 Port busy, output, 1: high while the FSM is in BURST.
REQ-014 Port grant_count, output, NUM_REQ*16: per-requester saturating beat counters, requester i in bits [i*16 +: 16].

Function
REQ-015 FSM states SHALL be IDLE and BURST, with registers owner, rr_ptr (both clog2(NUM_REQ) bits) and beat_cnt (5 bits).
REQ-016 In IDLE, sel SHALL be the first requester with req_valid high, searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ. In BURST, sel SHALL equal owner.
REQ-017 req_ready[sel] SHALL equal !fifo_full. All other req_ready bits SHALL be 0. In IDLE with no req_valid high, all req_ready bits SHALL be 0.
REQ-018 fifo_write_enable SHALL equal req_valid[sel] && req_ready[sel], combinationally, with zero-cycle latency. fifo_write_data SHALL equal the data slice of sel. grant_id SHALL equal sel.
REQ-019 IDLE with a transfer and MAX_BURST>1: next state BURST, owner<=sel, beat_cnt<=1.
REQ-020 IDLE with a transfer and MAX_BURST==1: stay in IDLE, rr_ptr<=sel+1 modulo NUM_REQ.
REQ-021 In BURST, a transfer SHALL increment beat_cnt. If the incremented value equals MAX_BURST, the next state SHALL be IDLE, rr_ptr<=owner+1 modulo NUM_REQ and beat_cnt<=0.
REQ-022 In BURST with req_valid[owner] low: no transfer, next state IDLE, rr_ptr<=owner+1 modulo NUM_REQ, beat_cnt<=0.
REQ-023 In BURST with fifo_full high and req_valid[owner] high: hold state, owner and beat_cnt; no transfer.
REQ-024 Requests from non-owners SHALL be ignored during BURST, with no starvation beyond one burst per other requester.
REQ-025 grant_count[i] SHALL increment by 1 on each transfer from requester i and saturate at 16'hFFFF.
REQ-026 busy SHALL equal (state==BURST).

Reset
REQ-027 While reset is high: state IDLE, rr_ptr 0, owner 0, beat_cnt 0, all grant_count 0, and req_ready and fifo_write_enable forced to 0 regardless of inputs.
REQ-028 Reset asserted mid-burst SHALL abandon the burst immediately, with no further FIFO write.
REQ-029 After release, arbitration SHALL resume at requester 0.

Structure
REQ-030 Package fifo_arb_pkg SHALL hold the FSM state enum (IDLE, BURST) and the default parameter constants.
REQ-031 One combinational sub-module, rr_picker, SHALL compute sel from req_valid and rr_ptr.

Verification (NUM_REQ=4, MAX_BURST=4)
REQ-032 Req 0 and req 2 valid continuously, fifo_full=0 -> 4 beats from 0, then 4 beats from 2, alternating; grant_count[0]=grant_count[2]=8 after 16 cycles.
REQ-033 Req 1 valid for 2 beats then drops -> 2 writes, one idle cycle, busy falls, rr_ptr=2.
REQ-034 fifo_full=1 for 3 cycles mid-burst (beat_cnt=2) -> req_ready=0 and no write for 3 cycles, then burst completes beats 3 and 4.
REQ-035 All 4 requesters valid, rr_ptr=3 -> grant order 3, 0, 1, 2, with each burst 4 beats.
REQ-036 Reset pulse during beat 2 of a burst -> fifo_write_enable=0 immediately; after release, req 0 is granted first and counters read 0.
REQ-037 Force grant_count[0]=16'hFFFE, then 3 transfers -> counter holds at 16'hFFFF.
